// File: rtl/instr_reg_exec.sv
`default_nettype none
// ============================================================================
//  Module   : instr_reg_exec
//  Purpose  : Instruction register file with a two-stage read/execute pipeline
//  Revision : 1.0  initial release
// ============================================================================
module instr_reg_exec #(
   parameter int OP_W  = 32,
   parameter int PTR_W = 5,
   parameter int OPC_W = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_en,
   input  logic [PTR_W-1:0]         write_pointer,
   input  logic [PTR_W-1:0]         read_pointer,
   input  logic [OPC_W-1:0]         opcode,
   input  logic [OP_W-1:0]          operand_a,
   input  logic [OP_W-1:0]          operand_b,
   output logic [OPC_W+2*OP_W-1:0]  instruction_word,
   output logic                     instr_valid,
   output logic [2*OP_W-1:0]        result,
   output logic                     result_valid,
   output logic                     div_by_zero
);

   localparam int c_DEPTH   = 2**PTR_W;
   localparam int c_ENTRY_W = OPC_W + 2*OP_W;
   localparam int c_RES_W   = 2*OP_W;

   localparam logic [OPC_W-1:0] c_OP_ZERO  = OPC_W'(0);
   localparam logic [OPC_W-1:0] c_OP_PASSA = OPC_W'(1);
   localparam logic [OPC_W-1:0] c_OP_PASSB = OPC_W'(2);
   localparam logic [OPC_W-1:0] c_OP_ADD   = OPC_W'(3);
   localparam logic [OPC_W-1:0] c_OP_SUB   = OPC_W'(4);
   localparam logic [OPC_W-1:0] c_OP_MULT  = OPC_W'(5);
   localparam logic [OPC_W-1:0] c_OP_DIV   = OPC_W'(6);
   localparam logic [OPC_W-1:0] c_OP_MOD   = OPC_W'(7);

   logic [c_ENTRY_W-1:0] r_mem [c_DEPTH];
   logic [c_DEPTH-1:0]   r_valid;

   logic [c_ENTRY_W-1:0] w_new_entry;
   logic                 w_bypass;

   assign w_new_entry = {opcode, operand_a, operand_b};
   assign w_bypass    = load_en && (write_pointer == read_pointer);

   // Register file and stage-1 read share one process so the bypass is exact.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_valid          <= '0;
         instruction_word <= '0;
         instr_valid      <= 1'b0;
      end else begin
         if (load_en) begin
            r_mem[write_pointer]   <= w_new_entry;
            r_valid[write_pointer] <= 1'b1;
         end
         if (w_bypass) begin
            instruction_word <= w_new_entry;
            instr_valid      <= 1'b1;
         end else begin
            instruction_word <= r_mem[read_pointer];
            instr_valid      <= r_valid[read_pointer];
         end
      end
   end

   logic [OPC_W-1:0]          w_opc;
   logic signed [c_RES_W-1:0] w_a;
   logic signed [c_RES_W-1:0] w_b;
   logic signed [c_RES_W-1:0] w_b_safe;
   logic signed [c_RES_W-1:0] w_result;
   logic                      w_div_zero;
   logic                      w_b_is_zero;

   assign w_opc = instruction_word[c_ENTRY_W-1 -: OPC_W];
   assign w_a   = {{OP_W{instruction_word[2*OP_W-1]}}, instruction_word[2*OP_W-1 -: OP_W]};
   assign w_b   = {{OP_W{instruction_word[OP_W-1]}}, instruction_word[OP_W-1:0]};
   assign w_b_is_zero = (w_b == '0);
   // Divisor forced non-zero so the divider never sees 0; the result is masked anyway.
   assign w_b_safe    = w_b_is_zero ? c_RES_W'(1) : w_b;

   always_comb begin
      w_result   = '0;
      w_div_zero = 1'b0;
      case (w_opc)
         c_OP_ZERO:  w_result = '0;
         c_OP_PASSA: w_result = w_a;
         c_OP_PASSB: w_result = w_b;
         c_OP_ADD:   w_result = w_a + w_b;
         c_OP_SUB:   w_result = w_a - w_b;
         c_OP_MULT:  w_result = w_a * w_b;
         c_OP_DIV: begin
            if (w_b_is_zero) w_div_zero = 1'b1;
            else             w_result   = w_a / w_b_safe;
         end
         c_OP_MOD: begin
            if (w_b_is_zero) w_div_zero = 1'b1;
            else             w_result   = w_a % w_b_safe;
         end
         default:    w_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result       <= '0;
         result_valid <= 1'b0;
         div_by_zero  <= 1'b0;
      end else begin
         result_valid <= instr_valid;
         result       <= instr_valid ? w_result : '0;
         div_by_zero  <= instr_valid & w_div_zero;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_reg_exec.sv
`default_nettype none
// Randomized scoreboard bench for instr_reg_exec: the driver predicts each
// edge's outputs from an arithmetic model; a monitor pops and compares.
module tb_instr_reg_exec;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_en = 1'b0;
   logic [4:0]  write_pointer = '0;
   logic [4:0]  read_pointer = '0;
   logic [2:0]  opcode = '0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic [66:0] instruction_word;
   logic        instr_valid;
   logic [63:0] result;
   logic        result_valid;
   logic        div_by_zero;

   instr_reg_exec #(.OP_W(32), .PTR_W(5), .OPC_W(3)) dut (
      .clk(clk), .reset(reset), .load_en(load_en),
      .write_pointer(write_pointer), .read_pointer(read_pointer),
      .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
      .instruction_word(instruction_word), .instr_valid(instr_valid),
      .result(result), .result_valid(result_valid), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [66:0] iw;
      bit          iv;
      logic [63:0] res;
      bit          rv;
      bit          dz;
   } exp_t;

   exp_t q_exp[$];
   int   total = 0;
   int   bad   = 0;

   // Reference storage: one slot per address, plain arrays.
   bit [2:0] m_opc [32];
   int       m_a   [32];
   int       m_b   [32];
   bit       m_v   [32];
   logic [66:0] prev_iw = '0;
   bit          prev_iv = 1'b0;

   function automatic void model_exec(input logic [66:0] iw,
                                      output longint res, output bit dz);
      int a;
      int b;
      a  = int'(iw[63:32]);
      b  = int'(iw[31:0]);
      dz = 1'b0;
      res = 0;
      case (iw[66:64])
         3'd1: res = longint'(a);
         3'd2: res = longint'(b);
         3'd3: res = longint'(a) + longint'(b);
         3'd4: res = longint'(a) - longint'(b);
         3'd5: res = longint'(a) * longint'(b);
         3'd6: if (b == 0) dz = 1'b1; else res = longint'(a) / longint'(b);
         3'd7: if (b == 0) dz = 1'b1; else res = longint'(a) % longint'(b);
         default: res = 0;
      endcase
   endfunction

   task automatic step(input bit rst, input bit le, input int wp, input int rp,
                       input int opc, input int a, input int b);
      exp_t   e;
      longint r;
      bit     z;
      @(negedge clk);
      reset         = rst;
      load_en       = le;
      write_pointer = 5'(wp);
      read_pointer  = 5'(rp);
      opcode        = 3'(opc);
      operand_a     = 32'(a);
      operand_b     = 32'(b);
      if (rst) begin
         e = '{iw: '0, iv: 1'b0, res: '0, rv: 1'b0, dz: 1'b0};
         for (int i = 0; i < 32; i++) begin
            m_opc[i] = '0; m_a[i] = 0; m_b[i] = 0; m_v[i] = 1'b0;
         end
      end else begin
         if (le && wp == rp) begin
            e.iw = {3'(opc), 32'(a), 32'(b)};
            e.iv = 1'b1;
         end else begin
            e.iw = {m_opc[rp], 32'(m_a[rp]), 32'(m_b[rp])};
            e.iv = m_v[rp];
         end
         model_exec(prev_iw, r, z);
         e.rv  = prev_iv;
         e.res = prev_iv ? 64'(r) : 64'd0;
         e.dz  = prev_iv & z;
         if (le) begin
            m_opc[wp] = 3'(opc); m_a[wp] = a; m_b[wp] = b; m_v[wp] = 1'b1;
         end
      end
      prev_iw = e.iw;
      prev_iv = e.iv;
      q_exp.push_back(e);
   endtask

   // Monitor: every edge presents a new stage-1 and stage-2 output.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            total++;
            if (instruction_word !== e.iw || instr_valid !== e.iv) begin
               bad++;
               $display("FAIL stage1 @%0t: got iw=%h iv=%b expected iw=%h iv=%b",
                        $time, instruction_word, instr_valid, e.iw, e.iv);
            end
            total++;
            if (result !== e.res || result_valid !== e.rv || div_by_zero !== e.dz) begin
               bad++;
               $display("FAIL stage2 @%0t: got res=%h rv=%b dz=%b expected res=%h rv=%b dz=%b",
                        $time, result, result_valid, div_by_zero, e.res, e.rv, e.dz);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int b;
      // Reset for two cycles, then read every address: nothing valid.
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) step(0, 0, 0, i, 0, 0, 0);
      // ADD 5 + -7 at address 3.
      step(0, 1, 3, 0, 3, 5, -7);
      step(0, 0, 0, 3, 0, 0, 0);
      step(0, 0, 0, 3, 0, 0, 0);
      // Same-edge write/read bypass with a full-width product.
      step(0, 1, 10, 10, 5, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      step(0, 0, 0, 10, 0, 0, 0);
      // Division and modulo corner cases.
      step(0, 1, 4, 4, 6, -7, 2);
      step(0, 1, 5, 5, 7, -7, 2);
      step(0, 1, 6, 6, 6, 9, 0);
      step(0, 1, 7, 7, 7, 9, 0);
      step(0, 1, 8, 8, 6, 32'h8000_0000, -1);
      step(0, 1, 9, 9, 7, 32'h8000_0000, -1);
      step(0, 1, 11, 11, 4, 32'h8000_0000, 1);
      step(0, 1, 12, 12, 1, -1, 0);
      step(0, 1, 13, 13, 2, 0, 32'h8000_0000);
      step(0, 1, 14, 14, 0, 123, 456);
      // Even-address load then a back-to-back sweep of all addresses.
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i += 2) step(0, 1, i, 1, 3, i, 100);
      for (int i = 0; i < 32; i++) step(0, 0, 0, i, 0, 0, 0);
      // Random traffic, including divisors of 0/-1 and the most negative dividend.
      for (int n = 0; n < 400; n++) begin
         a = ($urandom_range(0, 7) == 0) ? int'(32'h8000_0000) : int'($urandom);
         case ($urandom_range(0, 3))
            0: b = 0;
            1: b = -1;
            default: b = int'($urandom);
         endcase
         step(0, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 7), a, b);
      end
      // Reset with results in flight, then reread: everything invalid again.
      step(0, 1, 20, 20, 5, 3, 4);
      step(0, 1, 21, 21, 3, 1, 2);
      step(1, 1, 22, 22, 3, 1, 2);
      for (int i = 0; i < 32; i++) step(0, 0, 0, i, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #4;
      total++;
      if (q_exp.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
